// File: rtl/life_gen_sequencer_pkg.sv
// Shared definitions for the Game-of-Life generation sequencer: grid size,
// FSM encoding and the glider pattern loaded at reset.
package life_pkg;

  localparam int GRID_ROWS = 16;
  localparam int GRID_COLS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reset pattern: glider at (1,2),(2,3),(3,1),(3,2),(3,3).
  function automatic logic glider_cell(input int row, input int col);
    return ((row == 1) && (col == 2)) ||
           ((row == 2) && (col == 3)) ||
           ((row == 3) && (col >= 1) && (col <= 3));
  endfunction

endpackage

// File: rtl/life_gen_sequencer_if.sv
// Control, seeding and display signals of the generation sequencer.
interface life_gen_sequencer_if #(
  parameter int COLS = 16
) ();

  logic            frame_tick;
  logic            run;
  logic            step;
  logic            seed_we;
  logic [3:0]      seed_row;
  logic [COLS-1:0] seed_data;
  logic [3:0]      disp_row;
  logic [3:0]      disp_col;
  logic            disp_cell;
  logic            busy;
  logic            gen_done;
  logic [15:0]     gen_count;

  modport slave (
    input  frame_tick, run, step, seed_we, seed_row, seed_data, disp_row, disp_col,
    output disp_cell, busy, gen_done, gen_count
  );

  modport master (
    output frame_tick, run, step, seed_we, seed_row, seed_data, disp_row, disp_col,
    input  disp_cell, busy, gen_done, gen_count
  );

endinterface

// File: rtl/life_gen_sequencer_row_rule.sv
// B3/S23 next state of one row from its upper, own and lower neighbour rows;
// columns wrap around, so column COLS-1 neighbours column 0.
module life_row_rule #(
  parameter int COLS = 16
) (
  input  logic [COLS-1:0] above,
  input  logic [COLS-1:0] mid,
  input  logic [COLS-1:0] below,
  output logic [COLS-1:0] next_row
);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int L = (c + COLS - 1) % COLS;
    localparam int R = (c + 1) % COLS;

    logic [3:0] nbr;

    assign nbr = 4'(above[L]) + 4'(above[c]) + 4'(above[R]) +
                 4'(mid[L])                  + 4'(mid[R])   +
                 4'(below[L]) + 4'(below[c]) + 4'(below[R]);

    assign next_row[c] = (nbr == 4'd3) || (mid[c] && (nbr == 4'd2));
  end

endmodule

// File: rtl/life_gen_sequencer.sv
// Advances a toroidal Game-of-Life grid by one generation per frame tick,
// one row per clock, while the display reads the grid outside the update.
module life_gen_sequencer
  import life_pkg::*;
#(
  parameter int ROWS = GRID_ROWS,
  parameter int COLS = GRID_COLS
) (
  input logic                 clk,
  input logic                 rst_n,
  life_gen_sequencer_if.slave bus
);

  localparam int              PTR_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(ROWS - 1);

  state_t           state;
  logic [PTR_W-1:0] row_ptr;
  logic [COLS-1:0]  grid [ROWS];
  logic [COLS-1:0]  prev_row;
  logic [COLS-1:0]  first_row;
  logic             step_pending;
  logic             step_late;
  logic             busy_q;
  logic             gen_done_q;
  logic [15:0]      gen_count_q;

  logic [PTR_W-1:0] next_ptr;
  logic [COLS-1:0]  mid_row;
  logic [COLS-1:0]  below_row;
  logic [COLS-1:0]  next_row;
  logic             start_gen;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_ptr  = row_ptr + PTR_W'(1);
    mid_row   = grid[row_ptr];
    below_row = (row_ptr == LAST_ROW) ? first_row : grid[next_ptr];
    start_gen = bus.frame_tick && (bus.run || step_pending);
  end

  life_row_rule #(
    .COLS (COLS)
  ) u_rule (
    .above    (prev_row),
    .mid      (mid_row),
    .below    (below_row),
    .next_row (next_row)
  );

  // NOTE: all state here updates with <= so every read sees the value from
  // before the edge; prev_row takes the old row while that row is overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row_ptr      <= '0;
      prev_row     <= '0;
      first_row    <= '0;
      step_pending <= 1'b0;
      step_late    <= 1'b0;
      busy_q       <= 1'b0;
      gen_done_q   <= 1'b0;
      gen_count_q  <= '0;
      // NOTE: the grid is a bank of flops whose reset value is functional (the
      // glider), so it is reset on purpose; this also discards partial updates.
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          grid[r][c] <= glider_cell(r, c);
        end
      end
    end else begin
      gen_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.step) step_pending <= 1'b1;
          if (bus.seed_we) begin
            // A seed write wins over a tick in the same cycle; the tick is lost.
            if (int'(bus.seed_row) < ROWS) grid[bus.seed_row] <= bus.seed_data;
          end else if (start_gen) begin
            state     <= CALC;
            busy_q    <= 1'b1;
            row_ptr   <= '0;
            prev_row  <= grid[ROWS-1];
            first_row <= grid[0];
            if (bus.step) step_late <= 1'b1;
          end
        end

        CALC: begin
          if (bus.step) step_late <= 1'b1;
          grid[row_ptr] <= next_row;
          prev_row      <= mid_row;
          if (row_ptr == LAST_ROW) begin
            state       <= DONE;
            row_ptr     <= '0;
            gen_done_q  <= 1'b1;
            gen_count_q <= gen_count_q + 16'd1;
          end else begin
            row_ptr <= next_ptr;
          end
        end

        DONE: begin
          // The request that started this generation is consumed; a step seen
          // while busy survives to the following tick.
          step_pending <= step_late || bus.step;
          step_late    <= 1'b0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.disp_cell = grid[bus.disp_row][bus.disp_col];
  assign bus.busy      = busy_q;
  assign bus.gen_done  = gen_done_q;
  assign bus.gen_count = gen_count_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Directed bench for life_gen_sequencer against a whole-grid generation model.
`timescale 1ns/1ps
module tb_life_gen_sequencer;

  typedef bit [15:0] grid_t [16];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  life_gen_sequencer_if #(.COLS(16)) bus ();

  life_gen_sequencer #(.ROWS(16), .COLS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic grid_t glider();
    grid_t g;
    foreach (g[r]) g[r] = 16'h0;
    g[1] = 16'h0004;
    g[2] = 16'h0008;
    g[3] = 16'h000E;
    return g;
  endfunction

  function automatic grid_t life_step(input grid_t g);
    grid_t n;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        int cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              cnt += int'(g[(r + dr + 16) % 16][(c + dc + 16) % 16]);
        n[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
      end
    end
    return n;
  endfunction

  grid_t       m_grid, m_next;
  int          m_busy_left;
  bit          m_done, m_pend, m_late;
  logic [15:0] m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_grid = glider();
      m_busy_left = 0;
      m_done = 0; m_pend = 0; m_late = 0;
      m_count = 16'h0;
    end else begin
      m_done = 0;
      if (m_busy_left > 0) begin
        if (bus.step) m_late = 1;
        m_busy_left--;
        if (m_busy_left == 1) begin
          m_grid = m_next;
          m_done = 1;
          m_count = m_count + 16'd1;
        end else if (m_busy_left == 0) begin
          m_pend = m_late || bus.step;
          m_late = 0;
        end
      end else begin
        if (bus.seed_we) m_grid[bus.seed_row] = bus.seed_data;
        else if (bus.frame_tick && (bus.run || m_pend)) begin
          m_next = life_step(m_grid);
          m_busy_left = 17;
          if (bus.step) m_late = 1;
        end
        if (bus.step) m_pend = 1;
      end
    end
  end

  // Per-cycle compare of the registered status outputs.
  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(m_busy_left > 0));
    check("gen_done", 32'(bus.gen_done), 32'(m_done));
    check("gen_count", 32'(bus.gen_count), 32'(m_count));
  end

  // ---------------- stimulus helpers ----------------
  task automatic read_row(input int r, output logic [15:0] w);
    for (int c = 0; c < 16; c++) begin
      bus.disp_row = 4'(r);
      bus.disp_col = 4'(c);
      #1;
      w[c] = bus.disp_cell;
    end
  endtask

  task automatic check_grid(input string tag);
    logic [15:0] w;
    for (int r = 0; r < 16; r++) begin
      read_row(r, w);
      check($sformatf("%s_row%0d", tag, r), 32'(w), 32'(m_grid[r]));
    end
  endtask

  task automatic check_row_lit(input string tag, input int r, input logic [15:0] exp);
    logic [15:0] w;
    read_row(r, w);
    check(tag, 32'(w), 32'(exp));
  endtask

  task automatic seed(input int r, input logic [15:0] d);
    @(negedge clk);
    bus.seed_we = 1'b1; bus.seed_row = 4'(r); bus.seed_data = d;
    @(negedge clk);
    bus.seed_we = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, done_at;
    bus.frame_tick = 0; bus.run = 0; bus.step = 0; bus.seed_we = 0;
    bus.seed_row = 0; bus.seed_data = 0; bus.disp_row = 0; bus.disp_col = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset state: glider only.
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_count", 32'(bus.gen_count), 32'd0);
    check_row_lit("rst_r1", 1, 16'h0004);
    check_row_lit("rst_r2", 2, 16'h0008);
    check_row_lit("rst_r3", 3, 16'h000E);
    check_grid("rst");

    // Blinker: clear grid, seed row 5 cols 4-6, one generation.
    for (int r = 0; r < 16; r++) seed(r, (r == 5) ? 16'h0070 : 16'h0000);
    @(negedge clk);
    bus.frame_tick = 1'b1; bus.run = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0; bus.run = 1'b0;
    cyc = 0; done_at = 0;
    while (bus.busy && cyc < 40) begin
      cyc++;
      if (bus.gen_done) done_at = cyc;
      @(negedge clk);
    end
    check("blk_busy_len", 32'(cyc), 32'd17);
    check("blk_done_cyc", 32'(done_at), 32'd17);
    check("blk_count", 32'(bus.gen_count), 32'd1);
    check_row_lit("blk_r4", 4, 16'h0020);
    check_row_lit("blk_r5", 5, 16'h0020);
    check_row_lit("blk_r6", 6, 16'h0020);
    check_row_lit("blk_r7", 7, 16'h0000);
    check_grid("blk");

    // Glider: four generations move it by +1 row, +1 col.
    do_reset();
    bus.run = 1'b1;
    repeat (4) begin
      tick();
      wait_idle();
    end
    bus.run = 1'b0;
    check("gld_count", 32'(bus.gen_count), 32'd4);
    check_row_lit("gld_r1", 1, 16'h0000);
    check_row_lit("gld_r2", 2, 16'h0008);
    check_row_lit("gld_r3", 3, 16'h0010);
    check_row_lit("gld_r4", 4, 16'h001C);
    check_grid("gld");

    // Block split across all four corners stays still.
    for (int r = 0; r < 16; r++) seed(r, (r == 0 || r == 15) ? 16'h8001 : 16'h0000);
    bus.run = 1'b1;
    repeat (3) begin
      tick();
      wait_idle();
    end
    bus.run = 1'b0;
    check_row_lit("blkc_r0", 0, 16'h8001);
    check_row_lit("blkc_r15", 15, 16'h8001);
    check_row_lit("blkc_r1", 1, 16'h0000);
    check_grid("blkc");

    // Step during busy and seed during busy.
    do_reset();
    @(negedge clk);
    bus.frame_tick = 1'b1; bus.run = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0; bus.run = 1'b0;
    repeat (3) @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    bus.seed_we = 1'b1; bus.seed_row = 4'd8; bus.seed_data = 16'hFFFF;
    @(negedge clk);
    bus.seed_we = 1'b0;
    @(negedge clk);
    bus.frame_tick = 1'b1;  // ignored while busy
    @(negedge clk);
    bus.frame_tick = 1'b0;
    wait_idle();
    check("stp_count1", 32'(bus.gen_count), 32'd1);
    check_row_lit("stp_r8", 8, 16'h0000);
    check_grid("stp1");
    tick();
    wait_idle();
    check("stp_count2", 32'(bus.gen_count), 32'd2);
    tick();
    repeat (3) @(negedge clk);
    check("stp_nogen_busy", 32'(bus.busy), 32'd0);
    check("stp_count3", 32'(bus.gen_count), 32'd2);
    check_grid("stp2");

    // Seed beats tick in the same cycle; the pending step survives.
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    bus.seed_we = 1'b1; bus.seed_row = 4'd10; bus.seed_data = 16'h0100; bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.seed_we = 1'b0; bus.frame_tick = 1'b0;
    check("pri_busy", 32'(bus.busy), 32'd0);
    check_row_lit("pri_r10", 10, 16'h0100);
    tick();
    check("pri_start", 32'(bus.busy), 32'd1);
    wait_idle();
    check("pri_count", 32'(bus.gen_count), 32'd3);
    check_grid("pri");

    // Reset in the middle of an update restores the glider.
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy_pre", 32'(bus.busy), 32'd1);
    do_reset();
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_count", 32'(bus.gen_count), 32'd0);
    check_row_lit("mid_r3", 3, 16'h000E);
    check_grid("mid");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
